seg7_scan_display: RTL and testbench

Parametrised time-multiplexed seven-segment display driver for the DIP/LED/7-seg lab board family. It scans NUM_DIGITS digits one at a time: one-hot digit enable, active-high segments with DP on bit 7. Digit data is loaded atomically through a shadow register and applied only at frame boundaries. Adds per-digit blanking, decimal points, leading-zero blanking and per-digit blink.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_decode.sv | 20 ++
 rtl/seg7_scan_display.sv | 131 +++++++++++++
 tb/tb_seg7_scan_display.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: hex glyph table and decimal-point position.
// Segment bits are {dp,g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam int DP_BIT = 7;

    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return {1'b0, SEG_TABLE[nibble]};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Single-digit segment decoder: hex nibble plus decimal point, with a dark override.
// Combinational; shared with the single-digit lab blocks.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] seg
);

    always_comb begin
        seg         = hex_to_seg(nibble);
        seg[DP_BIT] = dp;
        if (dark) begin
            seg = '0;
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment scanner with shadowed digit data applied at
// frame boundaries, per-digit blank/blink/dp and live leading-zero blanking.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    lzb_en,
    output logic [NUM_DIGITS-1:0]   Enable,
    output logic [7:0]              SevenSeg,
    output logic                    busy,
    output logic                    frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [FRM_W-1:0]        frm_cnt;
    logic                    phase;

    logic [4*NUM_DIGITS-1:0] sh_digits, act_digits;
    logic [NUM_DIGITS-1:0]   sh_dp, act_dp;
    logic [NUM_DIGITS-1:0]   sh_blank, act_blank;
    logic [NUM_DIGITS-1:0]   sh_blink, act_blink;

    logic                    div_last;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    run;
    logic [3:0]              cur_nib;
    logic                    cur_dark;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   en_next;

    assign div_last   = (div_cnt == DIV_LAST);
    assign frame_end  = div_last && (digit_idx == IDX_LAST);
    assign frame_tick = frame_end;

    // lz[i]: digits N-1 down to i are all zero in the active set
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run   = run && (act_digits[4*i +: 4] == 4'h0);
            lz[i] = run;
        end
    end

    always_comb begin
        cur_nib  = act_digits[{digit_idx, 2'b00} +: 4];
        cur_dark = act_blank[digit_idx]
                 | (act_blink[digit_idx] & phase)
                 | (lzb_en && (digit_idx != '0) && lz[digit_idx]);
        en_next  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
    end

    seg7_decode u_decode (
        .nibble (cur_nib),
        .dp     (act_dp[digit_idx]),
        .dark   (cur_dark),
        .seg    (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            frm_cnt    <= '0;
            phase      <= 1'b0;
            busy       <= 1'b0;
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_blink   <= '0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blank  <= '1;
            act_blink  <= '0;
            Enable     <= '0;
            SevenSeg   <= '0;
        end else begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            if (div_last) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end
            if (frame_end && busy) begin
                act_digits <= sh_digits;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_blink  <= sh_blink;
            end
            // a load on the boundary cycle wins over the clear and waits a frame
            if (load) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_blink  <= blink_en;
                busy      <= 1'b1;
            end else if (frame_end) begin
                busy <= 1'b0;
            end
            if (frame_end) begin
                if (frm_cnt == FRM_LAST) begin
                    frm_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
            Enable   <= en_next;
            SevenSeg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (4 digits, 4-cycle scan, 2-frame blink).
// Stimulus queues expected per-digit outputs; a monitor checks each digit as it is enabled.
module tb_seg7_scan_display;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  blank_in = '0;
    logic [N-1:0]  blink_en = '0;
    logic          lzb_en = 1'b0;
    logic [N-1:0]  Enable;
    logic [7:0]    SevenSeg;
    logic          busy;
    logic          frame_tick;

    typedef struct {
        logic [3:0] en;
        logic [7:0] seg;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   fcount = 0;

    seg7_scan_display #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_en   (blink_en),
        .lzb_en     (lzb_en),
        .Enable     (Enable),
        .SevenSeg   (SevenSeg),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        sbq.push_back('{en: 4'b0001, seg: s0});
        sbq.push_back('{en: 4'b0010, seg: s1});
        sbq.push_back('{en: 4'b0100, seg: s2});
        sbq.push_back('{en: 4'b1000, seg: s3});
    endtask

    task automatic wait_tick();
        bit got = 1'b0;
        for (int i = 0; i < 4 * N * SD && !got; i++) begin
            @(negedge clk);
            if (frame_tick) got = 1'b1;
        end
        if (got) begin
            fcount++;
        end else begin
            tests++;
            fails++;
            $display("FAIL frame_tick_timeout got=none expected=pulse");
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] bl, input logic [3:0] bk);
        @(negedge clk);
        load      = 1'b1;
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
        blink_en  = bk;
        @(negedge clk);
        load = 1'b0;
    endtask

    // monitor: one comparison each time a new digit becomes enabled
    initial begin
        logic [3:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (Enable != prev) begin
                prev = Enable;
                if (Enable != '0 && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    tests++;
                    if (Enable !== e.en || SevenSeg !== e.seg) begin
                        fails++;
                        $display("FAIL scan_digit got en=%b seg=%h expected en=%b seg=%h",
                                 Enable, SevenSeg, e.en, e.seg);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ph;
        #2;
        check("reset_enable", {4'b0, Enable}, 8'h00);
        check("reset_seg", SevenSeg, 8'h00);
        check("reset_busy", {7'b0, busy}, 8'h00);
        check("reset_tick", {7'b0, frame_tick}, 8'h00);
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick();

        do_load(16'h1A3F, 4'b0010, 4'b0000, 4'b0000);
        check("busy_after_load", {7'b0, busy}, 8'h01);
        wait_tick();
        check("busy_at_tick", {7'b0, busy}, 8'h01);
        push_frame(8'h71, 8'hCF, 8'h77, 8'h06);
        @(negedge clk);
        check("busy_cleared", {7'b0, busy}, 8'h00);
        wait_tick();

        lzb_en = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000, 4'b0000);
        wait_tick();
        push_frame(8'h3F, 8'h6D, 8'h00, 8'h00);
        wait_tick();
        do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000);
        wait_tick();
        push_frame(8'h3F, 8'h00, 8'h00, 8'h00);
        wait_tick();
        lzb_en = 1'b0;

        do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
        load      = 1'b1;
        digits_in = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        wait_tick();
        push_frame(8'h5B, 8'h5B, 8'h5B, 8'h5B);

        do_load(16'h3333, 4'b0000, 4'b0000, 4'b0000);
        wait_tick();
        load      = 1'b1;
        digits_in = 16'h4444;
        push_frame(8'h4F, 8'h4F, 8'h4F, 8'h4F);
        @(negedge clk);
        load = 1'b0;
        check("busy_boundary_load", {7'b0, busy}, 8'h01);
        wait_tick();
        push_frame(8'h66, 8'h66, 8'h66, 8'h66);
        @(negedge clk);
        check("busy_deferred_clear", {7'b0, busy}, 8'h00);
        wait_tick();

        do_load(16'h8888, 4'b0000, 4'b0000, 4'b0001);
        wait_tick();
        for (int f = 0; f < 4; f++) begin
            ph = fcount[1];
            push_frame(ph ? 8'h00 : 8'h7F, 8'h7F, 8'h7F, 8'h7F);
            wait_tick();
        end

        do_load(16'h5555, 4'b0000, 4'b0000, 4'b0000);
        check("busy_before_reset", {7'b0, busy}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_enable", {4'b0, Enable}, 8'h00);
        check("async_seg", SevenSeg, 8'h00);
        check("async_busy", {7'b0, busy}, 8'h00);
        fcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        wait_tick();
        push_frame(8'h00, 8'h00, 8'h00, 8'h00);
        wait_tick();
        check("busy_after_reset", {7'b0, busy}, 8'h00);

        repeat (2) @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
